// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite to multi-slave APB bridge with wait-state support, decode/size checking,
// APB timeout abort and two-cycle AHB ERROR responses.
module ahb_apb_bridge_mc #(
    parameter int ADDR_W                  = 32,
    parameter int DATA_W                  = 32,
    parameter int NUM_SLV                 = 4,
    parameter int SEL_LSB                 = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h8000_0000),
    parameter int TIMEOUT                 = 16
) (
    input  logic                      clock,
    input  logic                      Hreset,
    input  logic                      Hreadyin,
    input  logic [1:0]                Htrans,
    input  logic                      Hwrite,
    input  logic [2:0]                Hsize,
    input  logic [2:0]                Hburst,
    input  logic [ADDR_W-1:0]         Haddr,
    input  logic [DATA_W-1:0]         Hwdata,
    output logic                      Hreadyout,
    output logic [1:0]                Hresp,
    output logic [DATA_W-1:0]         Hrdata,
    output logic [NUM_SLV-1:0]        Pselx,
    output logic                      Penable,
    output logic                      Pwrite,
    output logic [ADDR_W-1:0]         Paddr,
    output logic [DATA_W-1:0]         Pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] Prdata,
    input  logic [NUM_SLV-1:0]        Pready,
    input  logic [NUM_SLV-1:0]        Pslverr
);

    localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HI   = SEL_LSB + IDXW;
    localparam logic [2:0] MAX_SIZE = (DATA_W == 64) ? 3'd3 : 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } state_t;

    state_t              state_r, state_next;
    logic [IDXW-1:0]     idx_r, idx_next;
    logic [TW-1:0]       cnt_r, cnt_next;
    logic [IDXW-1:0]     idx_s;
    logic                hit_s, accept_s, timeout_s;
    logic                ready_sel_s, err_sel_s;
    logic [DATA_W-1:0]   rdata_sel_s;
    logic [ADDR_W-1:0]   paddr_next;
    logic                pwrite_next;
    logic [DATA_W-1:0]   pwdata_next, hrdata_next;
    logic [NUM_SLV-1:0]  pselx_next;
    logic                unused_s;

    assign unused_s  = ^{Hburst, Htrans[0]};
    assign idx_s     = Haddr[HI-1:SEL_LSB];
    assign hit_s     = (Haddr[ADDR_W-1:HI] == BASE_ADDR[ADDR_W-1:HI])
                     && ({{(32-IDXW){1'b0}}, idx_s} < NUM_SLV[31:0])
                     && (Hsize <= MAX_SIZE);
    assign accept_s  = (state_r == ST_IDLE) && Hreadyin && Htrans[1];
    assign timeout_s = (TIMEOUT != 0) && (cnt_r == TW'(TIMEOUT - 1));

    // Route the selected slave's response lines; other slaves are ignored.
    always_comb begin
        rdata_sel_s = '0;
        ready_sel_s = 1'b0;
        err_sel_s   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            rdata_sel_s = (idx_r == IDXW'(i)) ? Prdata[i*DATA_W +: DATA_W] : rdata_sel_s;
            ready_sel_s = (idx_r == IDXW'(i)) ? Pready[i] : ready_sel_s;
            err_sel_s   = (idx_r == IDXW'(i)) ? Pslverr[i] : err_sel_s;
        end
    end

    // Next-state and next-output computation; outputs are registered from these.
    always_comb begin
        state_next  = state_r;
        idx_next    = idx_r;
        cnt_next    = cnt_r;
        paddr_next  = Paddr;
        pwrite_next = Pwrite;
        pwdata_next = Pwdata;
        hrdata_next = Hrdata;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    paddr_next  = Haddr;
                    pwrite_next = Hwrite;
                    idx_next    = idx_s;
                    if (hit_s) begin
                        state_next = Hwrite ? ST_WDATA : ST_SETUP;
                    end else begin
                        state_next = ST_ERR1;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_WDATA: begin
                pwdata_next = Hwdata;
                state_next  = ST_SETUP;
            end
            ST_SETUP: begin
                cnt_next   = '0;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (ready_sel_s) begin
                    if (err_sel_s) begin
                        state_next = ST_ERR1;
                    end else begin
                        state_next  = ST_IDLE;
                        hrdata_next = Pwrite ? Hrdata : rdata_sel_s;
                    end
                end else begin
                    cnt_next   = cnt_r + TW'(1'b1);
                    state_next = timeout_s ? ST_ERR1 : ST_ACCESS;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            ST_ERR2: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_SLV; i++) begin
            pselx_next[i] = ((state_next == ST_SETUP) || (state_next == ST_ACCESS))
                            && (idx_next == IDXW'(i));
        end
    end

    // State, counter and registered bus outputs.
    always_ff @(posedge clock) begin
        if (Hreset) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            cnt_r     <= '0;
            Hreadyout <= 1'b1;
            Hresp     <= 2'b00;
            Hrdata    <= '0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
        end else begin
            state_r   <= state_next;
            idx_r     <= idx_next;
            cnt_r     <= cnt_next;
            Hreadyout <= (state_next == ST_IDLE) || (state_next == ST_ERR2);
            Hresp     <= ((state_next == ST_ERR1) || (state_next == ST_ERR2)) ? 2'b01 : 2'b00;
            Hrdata    <= hrdata_next;
            Pselx     <= pselx_next;
            Penable   <= (state_next == ST_ACCESS);
            Pwrite    <= pwrite_next;
            Paddr     <= paddr_next;
            Pwdata    <= pwdata_next;
        end
    end

endmodule
